alu_vector_sequencer: RTL and testbench
=======================================

// Module: alu_vector_sequencer
// PURPOSE
//  Upstream/downstream sequencing stage for the 4-bit vector ALU. Accepts one
//  operation request per valid/ready handshake and registers the operands and
//  opcode onto the ALU inputs. Waits a programmable settle time, then captures
//  the ALU result and overflow, and holds them on a valid/ready response port
//  until the consumer takes them. One operation is in flight at a time.
// PARAMETERS
//  WIDTH          4   operand/result width; must equal the ALU width
//  SETTLE_CYCLES  1   cycles between ALU input update and result capture (>=1)
//  CNT_W          8   width of completed-operation counter
// PORTS
//  wb_clk_i   in   1      single clock; all logic on rising edge
//  wb_rst_i   in   1      synchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      sequencer can accept a request
//  req_a      in   WIDTH  operand A
//  req_b      in   WIDTH  operand B
//  req_op     in   2      0=ADD 1=SUB 2=AND 3=GT ({CTRL1,CTRL0})
//  alu_a      out  WIDTH  to ALU A
//  alu_b      out  WIDTH  to ALU B
//  alu_ctrl0  out  1      to ALU CTRL0 (req_op[0])
//  alu_ctrl1  out  1      to ALU CTRL1 (req_op[1])
//  alu_c      in   WIDTH  from ALU C
//  alu_ovf    in   1      from ALU OVF
//  rsp_valid  out  1      captured result available
//  rsp_ready  in   1      consumer takes result
//  rsp_c      out  WIDTH  captured result
//  rsp_ovf    out  1      captured overflow/borrow bit
//  op_count   out  CNT_W  number of completed responses, wraps at 2^CNT_W
//  (vccd1/vssd1 inout under USE_POWER_PINS)
// BEHAVIOUR
//  - Reset (wb_rst_i=1 at an edge): state=IDLE and settle counter=0.
//    All data outputs and op_count go to 0; rsp_valid=0; req_ready=1 from the
//    next cycle. Reset overrides every event, including mid-SETTLE and in RESP;
//    an in-flight operation is dropped with no response.
//  - FSM states:
//    - IDLE: req_ready=1. On req_valid, at edge E0: alu_a/alu_b/alu_ctrl* <=
//      request; settle counter <= 0; go to SETTLE.
//    - SETTLE: req_ready=0. The counter increments each edge. At the edge where
//      counter==SETTLE_CYCLES-1: rsp_c<=alu_c, rsp_ovf<=alu_ovf; go to RESP.
//      Capture edge = E0+SETTLE_CYCLES. rsp_valid is high from the cycle after
//      the capture edge.
//    - RESP: rsp_valid=1, req_ready=0. rsp_c/rsp_ovf are stable. On rsp_ready,
//      at that edge: op_count++ (mod 2^CNT_W); go to IDLE. No same-cycle
//      accept of a new request.
//  - alu_* outputs hold their last value outside IDLE-accept edges.
//    rsp_c/rsp_ovf hold until the next capture.
//  - Throughput: one op per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
//  - req_valid while req_ready=0 is ignored. Request fields are don't-care then.
//  - SETTLE_CYCLES<1 is illegal; generate an elaboration error.
// STRUCTURE
//  - Shared include/package alu_vec_pkg: opcode localparams OP_ADD/OP_SUB/
//    OP_AND/OP_GT, state encodings ST_IDLE/ST_SETTLE/ST_RESP, default WIDTH.
//  - Single flat module with no sub-module. The ALU is instantiated alongside
//    this block at the next level up, not inside it.
// TESTING
//  - Reset: wb_rst_i=1 for 2 cycles -> req_ready=1, rsp_valid=0, op_count=0,
//    alu_a=alu_b=0.
//  - ADD A=9,B=8, rsp_ready=1 -> rsp_c=4'h1, rsp_ovf=1. rsp_valid is high
//    SETTLE_CYCLES+1 edges after accept; op_count=1.
//  - SUB A=3,B=5 -> rsp_c=4'hE, rsp_ovf=1.
//    AND A=C,B=A -> rsp_c=4'h8, rsp_ovf=0.
//    GT A=7,B=3 -> rsp_c=4'h1, rsp_ovf=0.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_c stable,
//    req_ready=0, a new req_valid is ignored; op_count unchanged until release.
//  - Reset mid-SETTLE with SETTLE_CYCLES=3 -> no rsp_valid pulse and
//    op_count=0. A following request completes normally.
//  - op_count wrap, CNT_W=2: 5 completed ops -> op_count=1.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// Shared definitions for the 4-bit vector ALU and its sequencing stage.
package alu_vec_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  // Opcodes as driven onto {CTRL1, CTRL0}
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_GT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_vector_sequencer.sv
// Request/response sequencer around the combinational vector ALU: registers
// operands onto the ALU, waits SETTLE_CYCLES, captures and holds the result.
module alu_vector_sequencer
  import alu_vec_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int          SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ctrl0,
  output logic             alu_ctrl1,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_ovf,
  output logic [CNT_W-1:0] op_count
);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_vector_sequencer: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    ctrl_d     = ctrl_q;
    rsp_c_d    = rsp_c_q;
    rsp_ovf_d  = rsp_ovf_q;
    op_count_d = op_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d = req_a;
          alu_b_d = req_b;
          ctrl_d  = req_op;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + SET_W'(1);
        if (cnt_q == SETTLE_LAST) begin
          rsp_c_d   = alu_c;
          rsp_ovf_d = alu_ovf;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered copies of the upcoming state
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ctrl_q      <= '0;
      rsp_c_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      op_count_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      ctrl_q      <= ctrl_d;
      rsp_c_q     <= rsp_c_d;
      rsp_ovf_q   <= rsp_ovf_d;
      op_count_q  <= op_count_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl0 = ctrl_q[0];
  assign alu_ctrl1 = ctrl_q[1];
  assign rsp_c     = rsp_c_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: two instances (SETTLE=1/CNT_W=8 and
// SETTLE=3/CNT_W=2), each wrapped around a behavioural ALU.
module tb_alu_vector_sequencer;
  import alu_vec_pkg::*;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2];
  logic         req_valid[2];
  logic         req_ready[2];
  logic [W-1:0] req_a[2];
  logic [W-1:0] req_b[2];
  logic [1:0]   req_op[2];
  logic [W-1:0] alu_a[2];
  logic [W-1:0] alu_b[2];
  logic         alu_ctrl0[2];
  logic         alu_ctrl1[2];
  logic [W-1:0] alu_c[2];
  logic         alu_ovf[2];
  logic         rsp_valid[2];
  logic         rsp_ready[2];
  logic [W-1:0] rsp_c[2];
  logic         rsp_ovf[2];
  logic [7:0]   op_count0;
  logic [1:0]   op_count1;

  int tests = 0;
  int fails = 0;
  logic [W:0] sbq0[$];
  logic [W:0] sbq1[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] c;
    logic         ovf;
  } vec_t;
  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  alu_vector_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(8)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl0(alu_ctrl0[0]), .alu_ctrl1(alu_ctrl1[0]),
    .alu_c(alu_c[0]), .alu_ovf(alu_ovf[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_c(rsp_c[0]), .rsp_ovf(rsp_ovf[0]), .op_count(op_count0)
  );

  alu_vector_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3), .CNT_W(2)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl0(alu_ctrl0[1]), .alu_ctrl1(alu_ctrl1[1]),
    .alu_c(alu_c[1]), .alu_ovf(alu_ovf[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_c(rsp_c[1]), .rsp_ovf(rsp_ovf[1]), .op_count(op_count1)
  );

  // Behavioural ALU, returns {C, OVF}; OVF is carry for ADD, borrow for SUB
  function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    logic [W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      default: r = (a > b) ? (W+1)'(1) : '0;
    endcase
    return {r[W-1:0], r[W]};
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++)
      {alu_c[k], alu_ovf[k]} = alu_model(alu_a[k], alu_b[k], {alu_ctrl1[k], alu_ctrl0[k]});
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: compare each response at its handshake
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst[0] && rsp_valid[0] && rsp_ready[0]) begin
      if (sbq0.size() == 0) check("rsp0_unexpected", 1, 0);
      else begin
        e = sbq0.pop_front();
        check("rsp0_c", int'(rsp_c[0]), int'(e[W:1]));
        check("rsp0_ovf", int'(rsp_ovf[0]), int'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst[1] && rsp_valid[1] && rsp_ready[1]) begin
      if (sbq1.size() == 0) check("rsp1_unexpected", 1, 0);
      else begin
        e = sbq1.pop_front();
        check("rsp1_c", int'(rsp_c[1]), int'(e[W:1]));
        check("rsp1_ovf", int'(rsp_ovf[1]), int'(e[0]));
      end
    end
  end

  // Issue one op on instance k, check response latency; completes the
  // handshake when rsp_ready is high. Called and returns at posedge+1.
  task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [W-1:0] ec, input logic eo);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("req_ready_timeout", 0, 1);
    req_valid[k] = 1'b1;
    req_a[k] = a;
    req_b[k] = b;
    req_op[k] = op;
    if (k == 0) sbq0.push_back({ec, eo});
    else        sbq1.push_back({ec, eo});
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("latency%0d", k), n, (k == 0) ? 1 : 3);
    if (rsp_ready[k]) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    vecs[0] = '{4'h9, 4'h8, OP_ADD, 4'h1, 1'b1};
    vecs[1] = '{4'h3, 4'h5, OP_SUB, 4'hE, 1'b1};
    vecs[2] = '{4'hC, 4'hA, OP_AND, 4'h8, 1'b0};
    vecs[3] = '{4'h7, 4'h3, OP_GT,  4'h1, 1'b0};
    vecs[4] = '{4'h3, 4'h4, OP_ADD, 4'h7, 1'b0};
    vecs[5] = '{4'hF, 4'h1, OP_ADD, 4'h0, 1'b1};
    vecs[6] = '{4'h5, 4'h3, OP_SUB, 4'h2, 1'b0};
    vecs[7] = '{4'h0, 4'h0, OP_SUB, 4'h0, 1'b0};
    vecs[8] = '{4'h3, 4'h7, OP_GT,  4'h0, 1'b0};
    vecs[9] = '{4'hF, 4'hF, OP_AND, 4'hF, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
      req_a[k] = '0; req_b[k] = '0; req_op[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;

    @(negedge clk);
    check("rst_req_ready", int'(req_ready[0]), 1);
    check("rst_rsp_valid", int'(rsp_valid[0]), 0);
    check("rst_op_count", int'(op_count0), 0);
    check("rst_alu_a", int'(alu_a[0]), 0);
    check("rst_alu_b", int'(alu_b[0]), 0);
    check("rst_rsp_c", int'(rsp_c[0]), 0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].ovf);
      check($sformatf("alu_in%0d", i), int'({alu_a[0], alu_b[0], alu_ctrl1[0], alu_ctrl0[0]}),
            int'({vecs[i].a, vecs[i].b, vecs[i].op}));
      check($sformatf("op_count%0d", i), int'(op_count0), i + 1);
    end

    // Backpressure: result held, new requests ignored
    rsp_ready[0] = 1'b0;
    do_op(0, 4'h6, 4'h5, OP_ADD, 4'hB, 1'b0);
    req_valid[0] = 1'b1; req_a[0] = 4'hF; req_b[0] = 4'hF; req_op[0] = OP_AND;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", int'(rsp_valid[0]), 1);
      check("bp_rsp_c", int'(rsp_c[0]), 'hB);
      check("bp_req_ready", int'(req_ready[0]), 0);
      check("bp_op_count", int'(op_count0), NVEC);
      check("bp_alu_a", int'(alu_a[0]), 'h6);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("bp_release_count", int'(op_count0), NVEC + 1);
    check("bp_release_valid", int'(rsp_valid[0]), 0);
    check("bp_release_ready", int'(req_ready[0]), 1);

    // Instance 1: reset mid-SETTLE drops the operation
    @(posedge clk); #1 rst[1] = 1'b0;
    @(negedge clk);
    check("rst1_req_ready", int'(req_ready[1]), 1);
    check("rst1_op_count", int'(op_count1), 0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_a[1] = 4'h9; req_b[1] = 4'h8; req_op[1] = OP_ADD;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1 rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    check("abort_no_rsp", int'(seen), 0);
    check("abort_op_count", int'(op_count1), 0);
    check("abort_req_ready", int'(req_ready[1]), 1);
    check("abort_rsp_c", int'(rsp_c[1]), 0);
    @(posedge clk); #1;

    // Following ops complete normally; counter wraps at 4
    do_op(1, 4'h7, 4'h3, OP_GT, 4'h1, 1'b0);
    check("wrap_count1", int'(op_count1), 1);
    for (int i = 0; i < 4; i++) begin
      do_op(1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].ovf);
      check($sformatf("wrap_count%0d", i + 2), int'(op_count1), (i + 2) % 4);
    end

    @(posedge clk); #1;
    check("sb0_drained", sbq0.size(), 0);
    check("sb1_drained", sbq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
